// File: rtl/vx_alu_pe_arbiter.sv
// Shares one in-order PE among NUM_REQS ALU blocks: round-robin grant, credit limit, tag FIFO for response routing.
// Latency: requests and responses pass through combinationally (0 cycles); state updates on the rising edge.
// Backpressure: req_ready follows pe_req_ready for the granted block only; pe_rsp_ready follows rsp_ready of the head tag.
module vx_alu_pe_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 64,
    parameter int RSPW         = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQS-1:0]                   req_valid,
    input  logic [NUM_REQS*DATAW-1:0]             req_data,
    output logic [NUM_REQS-1:0]                   req_ready,
    output logic [NUM_REQS-1:0]                   rsp_valid,
    output logic [RSPW-1:0]                       rsp_data,
    input  logic [NUM_REQS-1:0]                   rsp_ready,
    output logic                                  pe_req_valid,
    output logic [DATAW-1:0]                      pe_req_data,
    input  logic                                  pe_req_ready,
    input  logic                                  pe_rsp_valid,
    input  logic [RSPW-1:0]                       pe_rsp_data,
    output logic                                  pe_rsp_ready,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
    output logic                                  busy
);
    localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int SUMW = IDXW + 1;
    localparam int PTRW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNTW = $clog2(MAX_INFLIGHT + 1);

    logic [IDXW-1:0]     rr_ptr;
    logic [NUM_REQS-1:0] grant;
    logic [IDXW-1:0]     grant_idx;
    logic [SUMW-1:0]     sum;
    logic                found;
    logic                can_issue;
    logic                nonempty;
    logic                push;
    logic                pop;
    logic [IDXW-1:0]     head;
    logic [PTRW-1:0]     wr_ptr;
    logic [PTRW-1:0]     rd_ptr;
    logic [IDXW-1:0]     tag_mem [MAX_INFLIGHT];

    // Credits come from the registered count only, so a same-cycle pop never frees a slot.
    assign can_issue = !reset && (inflight < CNTW'(MAX_INFLIGHT));
    assign nonempty  = !reset && (inflight != '0);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            sum = {1'b0, rr_ptr} + SUMW'(k);
            if (sum >= SUMW'(NUM_REQS)) begin
                sum = sum - SUMW'(NUM_REQS);
            end
            if (can_issue && !found && req_valid[sum[IDXW-1:0]]) begin
                found                 = 1'b1;
                grant_idx             = sum[IDXW-1:0];
                grant[sum[IDXW-1:0]]  = 1'b1;
            end
        end
    end

    always_comb begin
        pe_req_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                pe_req_data = req_data[i*DATAW +: DATAW];
            end
        end
    end

    assign pe_req_valid = |grant;
    assign req_ready    = grant & {NUM_REQS{pe_req_ready}};

    assign head = tag_mem[rd_ptr];

    always_comb begin
        rsp_valid       = '0;
        rsp_valid[head] = pe_rsp_valid & nonempty;
    end

    assign rsp_data     = pe_rsp_data;
    assign pe_rsp_ready = nonempty & rsp_ready[head];

    assign push = pe_req_valid & pe_req_ready;
    assign pop  = pe_rsp_valid & pe_rsp_ready;
    assign busy = (inflight != '0);

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
                rr_ptr <= (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                inflight <= inflight + 1'b1;
            end else if (pop && !push) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    a_rsp_when_empty: assert property (@(posedge clk) disable iff (reset)
        !(pe_rsp_valid && inflight == '0));

    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (pe_req_valid && !pe_req_ready) |=> (pe_req_valid && $stable(pe_req_data)));

endmodule

// File: tb/tb_vx_alu_pe_arbiter.sv
// Directed bench for vx_alu_pe_arbiter: expected grants and responses are queued by stimulus, monitors pop and compare.
module tb_vx_alu_pe_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int RW = 32;
    localparam int MI = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [RW-1:0]     rsp_data;
    logic [NR-1:0]     rsp_ready;
    logic              pe_req_valid;
    logic [DW-1:0]     pe_req_data;
    logic              pe_req_ready;
    logic              pe_rsp_valid;
    logic [RW-1:0]     pe_rsp_data;
    logic              pe_rsp_ready;
    logic [2:0]        inflight;
    logic              busy;

    vx_alu_pe_arbiter #(.NUM_REQS(NR), .DATAW(DW), .RSPW(RW), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .pe_req_valid(pe_req_valid), .pe_req_data(pe_req_data), .pe_req_ready(pe_req_ready),
        .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data), .pe_rsp_ready(pe_rsp_ready),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [RW-1:0] d;
    } rsp_t;

    int   gq[$];
    rsp_t rq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ge;
    rsp_t re;
    logic          pend_v, nxt_v;
    logic [RW-1:0] pend_d, nxt_d;

    function automatic logic [DW-1:0] pay(input int i);
        return 64'hFEED_F00D_0000_0A00 + 64'(i);
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input int idx, input logic [RW-1:0] d);
        rsp_t r;
        r.idx = idx;
        r.d   = d;
        rq.push_back(r);
    endtask

    // Request-side monitor: every PE request fire must match the next expected grant.
    always @(negedge clk) begin
        if (!reset && pe_req_valid && pe_req_ready) begin
            if (gq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL grant_unexpected: got req_ready %b, required no fire", req_ready);
            end else begin
                ge = gq.pop_front();
                chk("grant_onehot", 64'(req_ready), 64'(onehot(ge)));
                chk("grant_payload", pe_req_data, pay(ge));
            end
        end
    end

    // Response-side monitor: every response fire must match the next expected routing/data.
    always @(negedge clk) begin
        if (!reset && |(rsp_valid & rsp_ready)) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid %b, required no response", rsp_valid);
            end else begin
                re = rq.pop_front();
                chk("rsp_route", 64'(rsp_valid), 64'(onehot(re.idx)));
                chk("rsp_data", 64'(rsp_data), 64'(re.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pay(i);
        reset        = 1'b0;
        req_valid    = '1;
        pe_req_ready = 1'b1;
        pe_rsp_valid = 1'b0;
        pe_rsp_data  = '0;
        rsp_ready    = '1;
        #1 reset = 1'b1;
        #11;
        chk("reset_req_ready", 64'(req_ready), 0);
        chk("reset_pe_req_valid", 64'(pe_req_valid), 0);
        chk("reset_rsp_valid", 64'(rsp_valid), 0);
        chk("reset_pe_rsp_ready", 64'(pe_rsp_ready), 0);
        chk("reset_inflight", 64'(inflight), 0);
        chk("reset_busy", 64'(busy), 0);
        req_valid = '0;
        tick();
        reset = 1'b0;

        // Round-robin with a one-cycle PE
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            gq.push_back(c % 4);
            push_rsp(c % 4, 32'h0000_0A00 + 32'(c % 4));
        end
        pend_v = 1'b0;
        pend_d = '0;
        for (int c = 0; c < 8; c++) begin
            pe_rsp_valid = pend_v;
            pe_rsp_data  = pend_d;
            @(negedge clk);
            chk("rr_inflight_le1", 64'(inflight <= 3'd1), 1);
            chk("rr_one_grant", 64'(pe_req_valid), 1);
            nxt_v = pe_req_valid && pe_req_ready;
            nxt_d = pe_req_data[RW-1:0];
            tick();
            pend_v = nxt_v;
            pend_d = nxt_d;
        end
        req_valid    = '0;
        pe_rsp_valid = pend_v;
        pe_rsp_data  = pend_d;
        tick();
        pe_rsp_valid = 1'b0;
        chk("rr_grants_drained", 64'(gq.size()), 0);

        // Credit limit: PE silent
        req_valid = '1;
        for (int i = 0; i < 4; i++) gq.push_back(i);
        repeat (7) tick();
        @(negedge clk);
        chk("credit_inflight", 64'(inflight), 4);
        chk("credit_busy", 64'(busy), 1);
        chk("credit_req_ready", 64'(req_ready), 0);
        chk("credit_pe_req_valid", 64'(pe_req_valid), 0);
        tick();

        // Full plus simultaneous pop
        pe_rsp_valid = 1'b1;
        pe_rsp_data  = 32'h100;
        push_rsp(0, 32'h100);
        gq.push_back(0);
        @(negedge clk);
        chk("fullpop_no_grant", 64'(pe_req_valid), 0);
        chk("fullpop_rsp_ready", 64'(pe_rsp_ready), 1);
        tick();
        pe_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fullpop_inflight", 64'(inflight), 3);
        chk("fullpop_grant_next", 64'(pe_req_valid), 1);
        tick();
        req_valid = '0;

        // Backpressure on head tag 1
        rsp_ready    = 4'b1101;
        pe_rsp_valid = 1'b1;
        pe_rsp_data  = 32'h201;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_pe_rsp_ready", 64'(pe_rsp_ready), 0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
            chk("bp_inflight", 64'(inflight), 4);
            tick();
        end
        rsp_ready = '1;
        push_rsp(1, 32'h201);
        @(negedge clk);
        chk("bp_release", 64'(pe_rsp_ready), 1);
        tick();
        pe_rsp_data = 32'h202;
        push_rsp(2, 32'h202);
        @(negedge clk);
        chk("bp_popped", 64'(inflight), 3);
        tick();
        pe_rsp_data = 32'h203;
        push_rsp(3, 32'h203);
        tick();
        pe_rsp_data = 32'h204;
        push_rsp(0, 32'h204);
        tick();
        pe_rsp_valid = 1'b0;
        @(negedge clk);
        chk("drain_inflight", 64'(inflight), 0);
        tick();

        // Response routing: fires from 2, 0, 3
        req_valid = 4'b0100; gq.push_back(2); tick();
        req_valid = 4'b0001; gq.push_back(0); tick();
        req_valid = 4'b1000; gq.push_back(3); tick();
        req_valid = '0;
        pe_rsp_valid = 1'b1;
        pe_rsp_data = 32'hA; push_rsp(2, 32'hA);
        @(negedge clk);
        chk("route_first", 64'(rsp_valid), 64'(4'b0100));
        tick();
        pe_rsp_data = 32'hB; push_rsp(0, 32'hB); tick();
        pe_rsp_data = 32'hC; push_rsp(3, 32'hC); tick();
        pe_rsp_valid = 1'b0;

        // Async reset with inflight=3, rr_ptr=2
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) gq.push_back(1);
        repeat (3) tick();
        req_valid    = '1;
        pe_req_ready = 1'b0;
        pe_rsp_valid = 1'b1;
        pe_rsp_data  = 32'hDEAD;
        rsp_ready    = '0;
        @(negedge clk);
        chk("pre_reset_inflight", 64'(inflight), 3);
        chk("pre_reset_stall_grant", pe_req_data, pay(2));
        chk("pre_reset_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        #2 reset = 1'b1;
        #1;
        chk("areset_req_ready", 64'(req_ready), 0);
        chk("areset_pe_req_valid", 64'(pe_req_valid), 0);
        chk("areset_rsp_valid", 64'(rsp_valid), 0);
        chk("areset_pe_rsp_ready", 64'(pe_rsp_ready), 0);
        chk("areset_inflight", 64'(inflight), 0);
        pe_rsp_valid = 1'b0;
        pe_req_ready = 1'b1;
        rsp_ready    = '1;
        repeat (2) tick();
        reset = 1'b0;
        gq.push_back(0);
        @(negedge clk);
        chk("post_reset_grant0", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid    = '0;
        pe_rsp_valid = 1'b1;
        pe_rsp_data  = 32'h77;
        push_rsp(0, 32'h77);
        tick();
        pe_rsp_valid = 1'b0;
        @(negedge clk);
        chk("final_inflight", 64'(inflight), 0);
        chk("final_grants_drained", 64'(gq.size()), 0);
        chk("final_rsps_drained", 64'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vx_alu_pe_arbiter.md
# VX_alu_pe_arbiter

Shares one long-latency ALU processing element (dot8 or muldiv) between `NUM_REQS` ALU blocks, so that a single PE instance serves several issue slices. It sits between the per-block PE switch outputs and the shared PE. It performs round-robin arbitration on requests, limits outstanding operations with a credit counter, and routes in-order PE responses back to the originating block through a tag FIFO.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesting ALU blocks (≥1).
- `DATAW`, 64: request payload width.
- `RSPW`, 32: response payload width.
- `MAX_INFLIGHT`, 4: maximum outstanding PE operations (≥1). Also the tag FIFO depth.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQS: per-block request valid.
- `req_data` in NUM_REQS*DATAW: per-block payload, block i at [i*DATAW +: DATAW].
- `req_ready` out NUM_REQS: per-block request accept.
- `rsp_valid` out NUM_REQS: per-block response valid (one-hot or zero).
- `rsp_data` out RSPW: response payload, broadcast to all blocks.
- `rsp_ready` in NUM_REQS: per-block response accept.
- `pe_req_valid` out 1, `pe_req_data` out DATAW, `pe_req_ready` in 1: request to the shared PE.
- `pe_rsp_valid` in 1, `pe_rsp_data` in RSPW, `pe_rsp_ready` out 1: response from the shared PE. The PE returns responses in request order.
- `inflight` out CLOG2(MAX_INFLIGHT+1): registered count of outstanding operations.
- `busy` out 1: `inflight != 0`.

The block uses one clock. Reset is asynchronous and active-high.

## Operation
- **State:**
  - Round-robin pointer `rr_ptr` (CLOG2(NUM_REQS) bits).
  - Credit counter `inflight`.
  - Tag FIFO of MAX_INFLIGHT entries, each CLOG2(NUM_REQS) bits (1 bit when NUM_REQS=1).
- **Grant:**
  - `can_issue = (inflight < MAX_INFLIGHT)`, using the registered count.
  - A pop in the same cycle does not free a credit; there is no bypass.
  - When `can_issue` is true, `grant` is the first asserted `req_valid` searching from `rr_ptr` upward, wrapping modulo NUM_REQS. Otherwise `grant` is zero.
- **Request path (combinational pass-through):**
  - `pe_req_valid = |grant`.
  - `pe_req_data` = payload of the granted block. It is zero when there is no grant.
  - `req_ready[i] = grant[i] & pe_req_ready`.
- **Request fire** (`pe_req_valid & pe_req_ready`):
  - Push the granted index into the tag FIFO.
  - Set `rr_ptr` to granted index + 1, wrapping to 0 after NUM_REQS-1.
  - The pointer does not move when nothing fires, including when the PE stalls.
- **Response path:**
  - `head` is the tag FIFO head and `nonempty = (inflight != 0)`.
  - `rsp_valid[head] = pe_rsp_valid & nonempty`. All other bits are 0.
  - `rsp_data = pe_rsp_data`.
  - `pe_rsp_ready = nonempty & rsp_ready[head]`.
- **Response fire:** pop the tag FIFO.
- **Counter update:**
  - Push only: `inflight + 1`.
  - Pop only: `inflight - 1`.
  - Push and pop in the same cycle: unchanged, with the FIFO read and write pointers both advancing.
- **Boundary conditions:**
  - Full (`inflight == MAX_INFLIGHT`): all `req_ready` = 0 and `pe_req_valid` = 0.
  - Empty: all `rsp_valid` = 0 and `pe_rsp_ready` = 0. `pe_rsp_valid` while empty is a protocol error and is flagged by a simulation assertion. The response is not consumed.
  - FIFO pointers wrap modulo MAX_INFLIGHT.
  - Stability assertions: once asserted, `pe_req_valid` and `pe_req_data` remain stable until fire.
  - Arbitration is not sticky: a requester that drops `req_valid` before fire loses its grant. Requesters must hold valid.
- **Reset:**
  - Effective immediately, including mid-operation.
  - `rr_ptr`=0, `inflight`=0, FIFO pointers=0.
  - While `reset` is high, `req_ready`=0, `pe_req_valid`=0, `rsp_valid`=0 and `pe_rsp_ready`=0, all forced.
  - Outstanding PE operations are discarded. The PE must be reset alongside this block.

## Timing
- Request latency: 0 cycles. Requester to PE is combinational.
- Response latency: 0 cycles. PE to requester is combinational.
- Throughput: one request and one response per cycle when credits are available.
- Full-credit recovery: after a pop at full, the next grant occurs no earlier than the following cycle.
- All state updates on the rising edge of `clk`.
- Reset values: `inflight`=0, `busy`=0, and all handshake outputs 0.

## Test plan
- **Round-robin fairness.** Stimulus: NUM_REQS=4, all requesters valid continuously, `pe_req_ready`=1, responses drained immediately. Required response: grant order 0,1,2,3,0,… with exactly one grant per cycle, and `inflight` never exceeds 1 with a 1-cycle PE.
- **Credit limit.** Stimulus: MAX_INFLIGHT=4, PE never responds, all requesters valid. Required response: exactly 4 fires, then `inflight`=4, `busy`=1 and all `req_ready`=0 indefinitely.
- **Response routing.** Stimulus: fires from blocks 2,0,3, then the PE returns 0xA, 0xB, 0xC. Required response: `rsp_valid` one-hot to 2, 0, 3 respectively, with `rsp_data` matching.
- **Backpressure.** Stimulus: head tag = 1 with `rsp_ready[1]`=0 for 3 cycles while `pe_rsp_valid`=1. Required response: `pe_rsp_ready`=0 for those cycles and no pop. The pop happens in the cycle `rsp_ready[1]` rises.
- **Full plus simultaneous pop.** Stimulus: `inflight`=4, a pop and a pending request in the same cycle. Required response: no grant that cycle, `inflight`=3 next cycle, and the grant fires the cycle after.
- **Async reset mid-operation.** Stimulus: `inflight`=3 and `rr_ptr`=2, then assert `reset` between clock edges. Required response: all handshake outputs 0 immediately, and after release `inflight`=0 with block 0 granted first.
